// File: rtl/demux_deser_1to8.sv
// demux_deser_1to8: serial-to-parallel 1-to-WIDTH demultiplexer.
// Bits are steered LSB first into an assembly register; finished words
// move to a holding register presented on a valid/ready handshake.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   DATA_IN    serial data bit
//   IN_VALID   DATA_IN valid this cycle
//   IN_READY   a bit can be accepted this cycle
//   FLUSH      synchronous abort of the partial/pending word
//   DATA_OUT   completed word (holding register)
//   OUT_VALID  DATA_OUT holds an unconsumed word
//   OUT_READY  consumer takes DATA_OUT this cycle
//   COUNT      word index the next accepted bit is written to
module demux_deser_1to8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             DATA_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [SEL_W-1:0] COUNT
);

    logic [WIDTH-1:0] asm_q, asm_d;
    logic [SEL_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             oval_q, oval_d;

    logic accept;
    logic last;
    logic drain;
    logic slot_free;

    // A bit offered during FLUSH is dropped even though IN_READY is high.
    assign accept    = IN_VALID & ~pend_q & ~FLUSH;
    assign last      = accept & (count_q == SEL_W'(WIDTH - 1));
    assign drain     = oval_q & OUT_READY;
    assign slot_free = ~oval_q | OUT_READY;

    always_comb begin
        asm_d   = asm_q;
        count_d = count_q;
        pend_d  = pend_q;
        dout_d  = dout_q;
        oval_d  = oval_q;

        if (accept) begin
            asm_d[count_q] = DATA_IN;
            count_d        = count_q + 1'b1;
        end

        // Drain first; a same-edge completion below may refill the slot.
        if (drain) begin
            if (pend_q) begin
                dout_d = asm_q;
                pend_d = 1'b0;
            end else begin
                oval_d = 1'b0;
            end
        end

        if (last) begin
            if (slot_free) begin
                dout_d = asm_d;
                oval_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        if (FLUSH) begin
            count_d = '0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            asm_q   <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            dout_q  <= '0;
            oval_q  <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            oval_q  <= oval_d;
        end
    end

    // Ready depends on state only, so there is no input-to-ready path.
    assign IN_READY  = ~pend_q;
    assign DATA_OUT  = dout_q;
    assign OUT_VALID = oval_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_demux_deser_1to8.sv
// tb_demux_deser_1to8: directed self-checking bench for demux_deser_1to8.
// Each task drives one scenario and checks against hand-computed values.
module tb_demux_deser_1to8;

    logic       CLK;
    logic       RST_N;
    logic       DATA_IN;
    logic       IN_VALID;
    logic       IN_READY;
    logic       FLUSH;
    logic [7:0] DATA_OUT;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [2:0] COUNT;

    int vectors;
    int miscompares;

    demux_deser_1to8 #(.WIDTH(8), .SEL_W(3)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DATA_IN   (DATA_IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .FLUSH     (FLUSH),
        .DATA_OUT  (DATA_OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stimulus only: shift one word in, LSB first, one bit per edge.
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            DATA_IN  = w[i];
            IN_VALID = 1'b1;
            tick();
        end
        IN_VALID = 1'b0;
        DATA_IN  = 1'b0;
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        DATA_IN   = 1'b0;
        FLUSH     = 1'b0;
        OUT_READY = 1'b0;
        #12;
        vectors++;
        if ({DATA_OUT, OUT_VALID, COUNT, IN_READY} !== {8'h00, 1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset: got dout=%h v=%b cnt=%0d rdy=%b, want 00 0 0 1",
                     DATA_OUT, OUT_VALID, COUNT, IN_READY);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'h4D;
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            DATA_IN  = w[i];
            IN_VALID = 1'b1;
            tick();
            if (i < 7) begin
                vectors++;
                if (COUNT !== 3'(i + 1) || OUT_VALID !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_count%0d: got cnt=%0d v=%b, want %0d 0",
                             i, COUNT, OUT_VALID, i + 1);
                end
            end
        end
        IN_VALID = 1'b0;
        vectors++;
        if (DATA_OUT !== 8'h4D || OUT_VALID !== 1'b1 || COUNT !== 3'd0) begin
            miscompares++;
            $display("FAIL basic_word: got dout=%h v=%b cnt=%0d, want 4d 1 0",
                     DATA_OUT, OUT_VALID, COUNT);
        end
        tick();
        vectors++;
        if (OUT_VALID !== 1'b0 || DATA_OUT !== 8'h4D) begin
            miscompares++;
            $display("FAIL basic_onecycle: got v=%b dout=%h, want 0 4d",
                     OUT_VALID, DATA_OUT);
        end
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        send_word(8'hA5);
        vectors++;
        if (DATA_OUT !== 8'hA5 || OUT_VALID !== 1'b1 || IN_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_wordA: got dout=%h v=%b rdy=%b, want a5 1 1",
                     DATA_OUT, OUT_VALID, IN_READY);
        end
        send_word(8'h3C);
        vectors++;
        if (DATA_OUT !== 8'hA5 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: got dout=%h v=%b rdy=%b, want a5 1 0",
                     DATA_OUT, OUT_VALID, IN_READY);
        end
        DATA_IN  = 1'b1;
        IN_VALID = 1'b1;
        tick();
        vectors++;
        if (COUNT !== 3'd0 || IN_READY !== 1'b0 || DATA_OUT !== 8'hA5) begin
            miscompares++;
            $display("FAIL bp_refuse: got cnt=%0d rdy=%b dout=%h, want 0 0 a5",
                     COUNT, IN_READY, DATA_OUT);
        end
        IN_VALID  = 1'b0;
        DATA_IN   = 1'b0;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        vectors++;
        if (DATA_OUT !== 8'h3C || OUT_VALID !== 1'b1 || IN_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drain: got dout=%h v=%b rdy=%b, want 3c 1 1",
                     DATA_OUT, OUT_VALID, IN_READY);
        end
        OUT_READY = 1'b1;
        tick();
        vectors++;
        if (OUT_VALID !== 1'b0 || DATA_OUT !== 8'h3C) begin
            miscompares++;
            $display("FAIL bp_empty: got v=%b dout=%h, want 0 3c",
                     OUT_VALID, DATA_OUT);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] w;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        words[2] = 8'h81;
        OUT_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = words[k];
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (IN_READY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready w%0d b%0d: got %b, want 1", k, i, IN_READY);
                end
                DATA_IN  = w[i];
                IN_VALID = 1'b1;
                tick();
            end
            vectors++;
            if (DATA_OUT !== words[k] || OUT_VALID !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_word%0d: got dout=%h v=%b, want %h 1",
                         k, DATA_OUT, OUT_VALID, words[k]);
            end
        end
        IN_VALID = 1'b0;
        tick();
        // Completion and drain on the same edge: no bubble.
        OUT_READY = 1'b0;
        send_word(8'h11);
        w = 8'h22;
        for (int i = 0; i < 8; i++) begin
            DATA_IN   = w[i];
            IN_VALID  = 1'b1;
            OUT_READY = (i == 7);
            tick();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        vectors++;
        if (DATA_OUT !== 8'h22 || OUT_VALID !== 1'b1 || IN_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_samedge: got dout=%h v=%b rdy=%b, want 22 1 1",
                     DATA_OUT, OUT_VALID, IN_READY);
        end
        OUT_READY = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        logic [7:0] w;
        OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DATA_IN  = 1'b1;
            IN_VALID = 1'b1;
            tick();
        end
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        vectors++;
        if (COUNT !== 3'd0 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_mid: got cnt=%0d rdy=%b v=%b, want 0 1 0",
                     COUNT, IN_READY, OUT_VALID);
        end
        send_word(8'h5A);
        vectors++;
        if (DATA_OUT !== 8'h5A || OUT_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clean: got dout=%h v=%b, want 5a 1",
                     DATA_OUT, OUT_VALID);
        end
        tick();
        // FLUSH on the last bit discards the completing word.
        w = 8'hE7;
        for (int i = 0; i < 8; i++) begin
            DATA_IN  = w[i];
            IN_VALID = 1'b1;
            FLUSH    = (i == 7);
            tick();
        end
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b0 || DATA_OUT !== 8'h5A || COUNT !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_last: got v=%b dout=%h cnt=%0d, want 0 5a 0",
                     OUT_VALID, DATA_OUT, COUNT);
        end
    endtask

    task automatic test_async_reset();
        OUT_READY = 1'b0;
        send_word(8'h96);
        for (int i = 0; i < 3; i++) begin
            DATA_IN  = 1'b1;
            IN_VALID = 1'b1;
            tick();
        end
        IN_VALID = 1'b0;
        vectors++;
        if (OUT_VALID !== 1'b1 || COUNT !== 3'd3) begin
            miscompares++;
            $display("FAIL areset_pre: got v=%b cnt=%0d, want 1 3", OUT_VALID, COUNT);
        end
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({DATA_OUT, OUT_VALID, COUNT, IN_READY} !== {8'h00, 1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL areset: got dout=%h v=%b cnt=%0d rdy=%b, want 00 0 0 1",
                     DATA_OUT, OUT_VALID, COUNT, IN_READY);
        end
        #3;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        logic [7:0] src;
        logic [2:0] sel;
        src = 8'hC3;
        OUT_READY = 1'b1;
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            DATA_IN  = src[sel];
            IN_VALID = 1'b1;
            tick();
            sel = sel + 3'd1;
        end
        IN_VALID = 1'b0;
        vectors++;
        if (DATA_OUT !== 8'hC3 || OUT_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL loopback: got dout=%h v=%b, want c3 1", DATA_OUT, OUT_VALID);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
